// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: entry layout, FSM states and
// a saturating increment used by the optional performance counters.
package ifq_pkg;

   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FULL
   } ifq_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ifq_if.sv
// Fetch-side and decode-side signals of the instruction fetch queue.
// The queue uses the master view; memory, branch unit and decode see the slave view.
interface ifq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rd;
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] instr_out;
   logic [WIDTH-1:0] pc_out;

   modport master (
      output imem_addr, instr_valid, instr_out, pc_out,
      input  imem_rd, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_addr, instr_valid, instr_out, pc_out,
      output imem_rd, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/ifq_storage.sv
// DEPTH x {pc, instr} register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module ifq_storage
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  ifq_entry_t               wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output ifq_entry_t               rdata_o
);

   ifq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: sequential imem fetch into a DEPTH-entry queue feeding decode,
// flushed by redirect. Define IFQ_PERF_EN to enable flush/stall counters.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   ifq_if.master        bus,
   output logic [15:0]  flush_cnt,
   output logic [15:0]  stall_cnt
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

   ifq_state_t       state_q, state_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             valid, push, pop;
   ifq_entry_t       head;

   assign valid = (count_q != '0);
   assign pop   = valid & bus.instr_ready & ~bus.redirect;
   assign push  = (state_q != S_BOOT) & ~bus.redirect & ((count_q < FULL_CNT) | pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (bus.redirect) begin
         // Redirect discards everything in flight and restarts at the word-aligned target.
         state_d    = S_RUN;
         fetch_pc_d = {bus.redirect_pc[WIDTH-1:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            fetch_pc_d = fetch_pc_q + WIDTH'(INSTR_BYTES);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
         case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (count_d == FULL_CNT && !pop) state_d = S_FULL;
            S_FULL:  if (pop) state_d = S_RUN;
            default: state_d = S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   ifq_storage #(.DEPTH(DEPTH)) u_storage (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i ('{pc: fetch_pc_q, instr: bus.imem_rd}),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // Storage is unreset, so head fields are masked to 0 while the queue is empty.
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr_out   = valid ? head.instr : '0;
   assign bus.pc_out      = valid ? head.pc    : '0;

`ifdef IFQ_PERF_EN
   logic [15:0] flush_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         if (bus.redirect) flush_cnt_q <= sat_inc16(flush_cnt_q);
         if (state_q == S_FULL && !pop) stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
   end

   assign flush_cnt = flush_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign flush_cnt = 16'd0;
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0); imem returns PC^32'hA5A5_0000.
// Counter expectations follow IFQ_PERF_EN as defined for the build.
module tb_instr_fetch_queue;

   logic        clk;
   logic        rst;
   logic [15:0] flush_cnt;
   logic [15:0] stall_cnt;
   int          checks;
   int          errors;

`ifdef IFQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   ifq_if #(.WIDTH(32)) bus ();

   instr_fetch_queue #(
      .WIDTH    (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .flush_cnt (flush_cnt),
      .stall_cnt (stall_cnt)
   );

   assign bus.imem_rd = bus.imem_addr ^ 32'hA5A5_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed=running required=finished");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] iw(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] perf(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.instr_ready = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_pc_out", bus.pc_out, 32'h0);
      chk("rst_instr_out", bus.instr_out, 32'h0);
      chk("rst_flush", 32'(flush_cnt), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);

      // Release: boot cycle, then first push; valid two clocks after release
      rst = 1'b1;
      chk("boot_valid0", 32'(bus.instr_valid), 32'd0);
      tick();
      chk("boot_valid1", 32'(bus.instr_valid), 32'd0);
      chk("boot_addr", bus.imem_addr, 32'h0);
      tick();
      chk("t1_valid", 32'(bus.instr_valid), 32'd1);
      chk("t1_pc0", bus.pc_out, 32'h0);
      chk("t1_instr0", bus.instr_out, iw(32'h0));
      chk("t1_addr4", bus.imem_addr, 32'h4);
      tick();
      chk("t1_pc4", bus.pc_out, 32'h4);
      tick();
      chk("t1_pc8", bus.pc_out, 32'h8);
      chk("t1_addrC", bus.imem_addr, 32'hC);

      // Redirect to 0, then hold decode off for 10 cycles
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0;
      bus.instr_ready = 1'b0;
      tick();
      bus.redirect = 1'b0;
      chk("t2_valid_after_redir", 32'(bus.instr_valid), 32'd0);
      chk("t2_addr_restart", bus.imem_addr, 32'h0);
      repeat (4) tick();
      chk("t2_addr_full", bus.imem_addr, 32'h10);
      repeat (6) tick();
      chk("t2_addr_hold", bus.imem_addr, 32'h10);
      chk("t2_valid", 32'(bus.instr_valid), 32'd1);
      chk("t2_head", bus.pc_out, 32'h0);
      chk("t2_stall", 32'(stall_cnt), perf(6));
      chk("t2_flush", 32'(flush_cnt), perf(1));

      // Drain in order with no bubble; full queue keeps fetching 1/cycle
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("t3_valid%0d", i), 32'(bus.instr_valid), 32'd1);
         chk($sformatf("t3_pc%0d", i), bus.pc_out, 32'(i * 4));
         chk($sformatf("t3_instr%0d", i), bus.instr_out, iw(32'(i * 4)));
         chk($sformatf("t3_addr%0d", i), bus.imem_addr, 32'(i * 4 + 16));
         tick();
      end
      chk("t3_stall_hold", 32'(stall_cnt), perf(6));

      // Redirect to misaligned 0x103 during a valid&ready cycle
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h103;
      tick();
      bus.redirect = 1'b0;
      chk("t4_valid0", 32'(bus.instr_valid), 32'd0);
      chk("t4_pc_masked", bus.pc_out, 32'h0);
      chk("t4_addr", bus.imem_addr, 32'h100);
      tick();
      chk("t4_valid1", 32'(bus.instr_valid), 32'd1);
      chk("t4_pc", bus.pc_out, 32'h100);
      chk("t4_instr", bus.instr_out, iw(32'h100));
      chk("t4_flush", 32'(flush_cnt), perf(2));

      // Back-to-back redirects: the last one wins
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h200;
      tick();
      bus.redirect_pc = 32'h300;
      tick();
      bus.redirect = 1'b0;
      chk("b2b_valid0", 32'(bus.instr_valid), 32'd0);
      chk("b2b_addr", bus.imem_addr, 32'h300);
      tick();
      chk("b2b_pc", bus.pc_out, 32'h300);
      chk("b2b_flush", 32'(flush_cnt), perf(4));

      // Fetch PC wraps through zero
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFF8;
      tick();
      bus.redirect = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t6_valid%0d", i), 32'(bus.instr_valid), 32'd1);
         chk($sformatf("t6_pc%0d", i), bus.pc_out, 32'hFFFF_FFF8 + 32'(i * 4));
         tick();
      end
      chk("t6_flush", 32'(flush_cnt), perf(5));

      // Build count=3, then assert reset mid-cycle
      bus.instr_ready = 1'b0;
      tick(); tick();
      chk("t5_valid_pre", 32'(bus.instr_valid), 32'd1);
      chk("t5_head_pre", bus.pc_out, 32'h8);
      chk("t5_addr_pre", bus.imem_addr, 32'h14);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_valid_async", 32'(bus.instr_valid), 32'd0);
      chk("t5_addr_async", bus.imem_addr, 32'h0);
      chk("t5_pc_async", bus.pc_out, 32'h0);
      chk("t5_flush_clr", 32'(flush_cnt), 32'd0);
      chk("t5_stall_clr", 32'(stall_cnt), 32'd0);
      bus.instr_ready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("t5_boot_valid", 32'(bus.instr_valid), 32'd0);
      tick();
      chk("t5_restart_valid", 32'(bus.instr_valid), 32'd1);
      chk("t5_restart_pc0", bus.pc_out, 32'h0);
      tick();
      chk("t5_restart_pc4", bus.pc_out, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
